// File: rtl/pipeline_wb_skid_stage.sv
// Writeback skid stage: main + skid register, registered in_ready, jal link rewrite, stall counter.
// Latency 1 cycle; in_ready drops only when the skid entry fills. `WB_BYPASS_EN adds decode-forwarding outputs.
module pipeline_wb_skid_stage #(
  parameter int DSIZE    = 32,
  parameter int ASIZE    = 5,
  parameter int ISIZE    = 16,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wen_in,
  input  logic [ASIZE-1:0] w_addr_in,
  input  logic [DSIZE-1:0] w_data_in,
  input  logic [ISIZE-1:0] PC_in,
  input  logic             jal_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wen_out,
  output logic [ASIZE-1:0] w_addr_out,
  output logic [DSIZE-1:0] w_data_out,
  output logic [ISIZE-1:0] PC_out,
  output logic             jal_out,
`ifdef WB_BYPASS_EN
  output logic             byp_valid,
  output logic [ASIZE-1:0] byp_addr,
  output logic [DSIZE-1:0] byp_data,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_vld_q, main_vld_d;
  logic             main_wen_q, main_wen_d;
  logic [ASIZE-1:0] main_addr_q, main_addr_d;
  logic [DSIZE-1:0] main_data_q, main_data_d;
  logic [ISIZE-1:0] main_pc_q, main_pc_d;
  logic             main_jal_q, main_jal_d;

  logic             skid_vld_q, skid_vld_d;
  logic             skid_wen_q, skid_wen_d;
  logic [ASIZE-1:0] skid_addr_q, skid_addr_d;
  logic [DSIZE-1:0] skid_data_q, skid_data_d;
  logic [ISIZE-1:0] skid_pc_q, skid_pc_d;
  logic             skid_jal_q, skid_jal_d;

  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             accept;
  logic             new_wen;
  logic [ASIZE-1:0] new_addr;
  logic [DSIZE-1:0] new_data;
  logic [ISIZE-1:0] pc_plus1;

  assign accept   = in_valid & in_ready_q;
  assign pc_plus1 = PC_in + ISIZE'(1);

  // jal writes the zero-extended return address into the link register; r0 is never written.
  always_comb begin
    new_addr = jal_in ? ASIZE'(LINK_REG) : w_addr_in;
    new_data = w_data_in;
    if (jal_in) begin
      new_data = '0;
      new_data[ISIZE-1:0] = pc_plus1;
    end
    new_wen = (wen_in | jal_in) & (new_addr != '0);
  end

  always_comb begin
    main_vld_d  = main_vld_q;
    main_wen_d  = main_wen_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    main_jal_d  = main_jal_q;
    skid_vld_d  = skid_vld_q;
    skid_wen_d  = skid_wen_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    skid_jal_d  = skid_jal_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      // in_ready_q is low whenever skid is full, so skid refill and accept never coincide here.
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_wen_d  = skid_wen_q;
        main_addr_d = skid_addr_q;
        main_data_d = skid_data_q;
        main_pc_d   = skid_pc_q;
        main_jal_d  = skid_jal_q;
        skid_vld_d  = 1'b0;
      end else if (accept) begin
        main_vld_d  = 1'b1;
        main_wen_d  = new_wen;
        main_addr_d = new_addr;
        main_data_d = new_data;
        main_pc_d   = PC_in;
        main_jal_d  = jal_in;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_wen_d  = new_wen;
      skid_addr_d = new_addr;
      skid_data_d = new_data;
      skid_pc_d   = PC_in;
      skid_jal_d  = jal_in;
    end
    in_ready_d = ~skid_vld_d;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_vld_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_wen_q  <= 1'b0;
      main_addr_q <= '0;
      main_data_q <= '0;
      main_pc_q   <= '0;
      main_jal_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_wen_q  <= main_wen_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      main_jal_q  <= main_jal_d;
      skid_vld_q  <= skid_vld_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Skid payload is qualified by skid_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_wen_q  <= skid_wen_d;
    skid_addr_q <= skid_addr_d;
    skid_data_q <= skid_data_d;
    skid_pc_q   <= skid_pc_d;
    skid_jal_q  <= skid_jal_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_vld_q;
  assign wen_out    = main_vld_q & main_wen_q;
  assign w_addr_out = main_addr_q;
  assign w_data_out = main_data_q;
  assign PC_out     = main_pc_q;
  assign jal_out    = main_jal_q;
  assign stall_cnt  = stall_cnt_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = main_vld_q & main_wen_q;
  assign byp_addr  = main_addr_q;
  assign byp_data  = main_data_q;
`endif

endmodule

// File: tb/tb_pipeline_wb_skid_stage.sv
// Directed bench for pipeline_wb_skid_stage with default parameters.
module tb_pipeline_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        wen_in, jal_in, out_valid, out_ready;
  logic [4:0]  w_addr_in, w_addr_out;
  logic [31:0] w_data_in, w_data_out;
  logic [15:0] PC_in, PC_out;
  logic        wen_out, jal_out;
  logic [15:0] stall_cnt;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_wb_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wen_in(wen_in), .w_addr_in(w_addr_in), .w_data_in(w_data_in),
    .PC_in(PC_in), .jal_in(jal_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wen_out(wen_out), .w_addr_out(w_addr_out), .w_data_out(w_data_out),
    .PC_out(PC_out), .jal_out(jal_out),
`ifdef WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
`endif
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [15:0] pc, input logic j);
    in_valid  = v;
    wen_in    = w;
    w_addr_in = a;
    w_data_in = d;
    PC_in     = pc;
    jal_in    = j;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'h1234_5678, 16'h0100, 1'b1);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wen",       wen_out, 0);
    chk("rst_jal",       jal_out, 0);
    chk("rst_addr",      w_addr_out, 0);
    chk("rst_data",      w_data_out, 0);
    chk("rst_pc",        PC_out, 0);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_in_ready",  in_ready, 1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    rst = 1'b0;
    step();

    // single transfer, one-cycle latency
    drive(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 16'h0010, 1'b0);
    step();
    chk("basic_valid", out_valid, 1);
    chk("basic_addr",  w_addr_out, 3);
    chk("basic_data",  w_data_out, 32'hDEAD_BEEF);
    chk("basic_wen",   wen_out, 1);
    drive(1'b0, 1'b1, 5'd4, 32'h0, 16'h0, 1'b0);
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_wen",   wen_out, 0);
    chk("idle_hold",  w_data_out, 32'hDEAD_BEEF);

    // jal link rewrite and PC wrap
    drive(1'b1, 1'b0, 5'd7, 32'hCAFE_0000, 16'h0040, 1'b1);
    step();
    chk("jal_addr", w_addr_out, 31);
    chk("jal_data", w_data_out, 32'h0000_0041);
    chk("jal_wen",  wen_out, 1);
    chk("jal_flag", jal_out, 1);
    chk("jal_pc",   PC_out, 16'h0040);
    drive(1'b1, 1'b0, 5'd7, 32'hCAFE_0000, 16'hFFFF, 1'b1);
    step();
    chk("jal_wrap", w_data_out, 0);

    // r0 destination never writes
    drive(1'b1, 1'b1, 5'd0, 32'h5555_AAAA, 16'h0002, 1'b0);
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_wen",   wen_out, 0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    step();

    // backpressure: A to main, B to skid, C refused
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 32'h0000_000A, 16'h0001, 1'b0);
    step();
    chk("stA_data",  w_data_out, 32'hA);
    chk("stA_rdy",   in_ready, 1);
    chk("stA_stall", stall_cnt, 0);
    drive(1'b1, 1'b1, 5'd2, 32'h0000_000B, 16'h0002, 1'b0);
    step();
    chk("stB_rdy",   in_ready, 0);
    chk("stB_data",  w_data_out, 32'hA);
    chk("stB_stall", stall_cnt, 1);
    drive(1'b1, 1'b1, 5'd5, 32'h0000_000C, 16'h0003, 1'b0);
    step();
    chk("stC_rdy",   in_ready, 0);
    chk("stC_stall", stall_cnt, 2);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("drA_data",  w_data_out, 32'hB);
    chk("drA_addr",  w_addr_out, 2);
    chk("drA_valid", out_valid, 1);
    chk("drA_rdy",   in_ready, 1);
    step();
    chk("drB_valid", out_valid, 0);
    chk("drB_data",  w_data_out, 32'hB);
    chk("drB_stall", stall_cnt, 2);

    // flush with both entries full and a new beat offered
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd6, 32'h0000_000D, 16'h0004, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'd8, 32'h0000_000E, 16'h0005, 1'b0);
    step();
    chk("fl_full_rdy", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'h0000_000F, 16'h0006, 1'b0);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy",   in_ready, 1);
    chk("fl_stall", stall_cnt, 4);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    step();
    chk("fl_nonew_valid", out_valid, 0);
    chk("fl_nonew_data",  w_data_out, 32'hD);

    // reset overrides a full, stalled stage
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd10, 32'h0000_0011, 16'h0007, 1'b1);
    step();
    drive(1'b1, 1'b1, 5'd11, 32'h0000_0022, 16'h0008, 1'b0);
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_wen",   wen_out, 0);
    chk("mrst_jal",   jal_out, 0);
    chk("mrst_addr",  w_addr_out, 0);
    chk("mrst_data",  w_data_out, 0);
    chk("mrst_pc",    PC_out, 0);
    chk("mrst_stall", stall_cnt, 0);
    chk("mrst_rdy",   in_ready, 1);
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    step();
    chk("mrst_after_valid", out_valid, 0);

    // stall counter saturation
    drive(1'b1, 1'b1, 5'd12, 32'h0000_0033, 16'h0009, 1'b0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 1'b0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("sat_below", stall_cnt, 16'hFFFE);
    step();
    chk("sat_reach", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    chk("sat_hold",  stall_cnt, 16'hFFFF);
    chk("sat_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
